// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, buffers ROM words in a small prefetch queue
// and presents the head to IF/ID. Optional self-loop halt detection under `HALT_DETECT_EN.
module if_fetch_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              rom_addr,
  input  logic [31:0]              rom_inst,
  input  logic                     stall,
  input  logic                     br_taken,
  input  logic [31:0]              br_target,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              pc_out,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     halted
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [31:0] JMP_SELF = 32'hA800_FFFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        inst_q [DEPTH];
  logic [31:0]        inst_d [DEPTH];
  logic [31:0]        pca_q  [DEPTH];
  logic [31:0]        pca_d  [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic [31:0]        pc_out_q, pc_out_d;

  logic               pop;
  logic               push;
  logic               flush;
  logic               halt_hit;
  logic [CNT_W-1:0]   wr_idx;

  // Entry 0 is always the head; slots at or beyond count_q are kept at zero so inst reads 0 when empty.
  always_comb begin
    pop        = valid_q & ~stall & ~br_taken;
    halt_hit   = 1'b0;
`ifdef HALT_DETECT_EN
    halt_hit   = pop & (inst_q[0] == JMP_SELF);
`endif
    flush      = br_taken | halt_hit | (state_q == ST_HALT);
    push       = ~flush & ((state_q == ST_REDIR) |
                           ((state_q == ST_RUN) & ((count_q < CNT_W'(DEPTH)) | pop)));
    wr_idx     = count_q - CNT_W'(pop);

    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      inst_d[i] = pop ? inst_q[i+1] : inst_q[i];
      pca_d[i]  = pop ? pca_q[i+1]  : pca_q[i];
    end
    inst_d[DEPTH-1] = pop ? 32'h0 : inst_q[DEPTH-1];
    pca_d[DEPTH-1]  = pop ? 32'h0 : pca_q[DEPTH-1];

    if (push) begin
      inst_d[PTR_W'(wr_idx)] = rom_inst;
      pca_d[PTR_W'(wr_idx)]  = fetch_pc_q;
    end
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_d[i] = 32'h0;
        pca_d[i]  = 32'h0;
      end
    end

    count_d    = flush ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
    valid_d    = (count_d != '0);
    pc_out_d   = valid_d ? (pca_d[0] + 32'd4) : pc_out_q;

    fetch_pc_d = fetch_pc_q;
    if (br_taken)  fetch_pc_d = br_target;
    else if (push) fetch_pc_d = fetch_pc_q + 32'd4;

    state_d    = state_q;
    if (br_taken)                 state_d = ST_REDIR;
    else if (halt_hit)            state_d = ST_HALT;
    else if (state_q == ST_REDIR) state_d = ST_RUN;
  end

  // State and queue registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      valid_q    <= 1'b0;
      pc_out_q   <= 32'h0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_q[i] <= 32'h0;
        pca_q[i]  <= 32'h0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      pc_out_q   <= pc_out_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_q[i] <= inst_d[i];
        pca_q[i]  <= pca_d[i];
      end
    end
  end

`ifdef HALT_DETECT_EN
  logic halted_q;

  always_ff @(posedge clk) begin
    if (!rst) halted_q <= 1'b0;
    else      halted_q <= (state_d == ST_HALT);
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign rom_addr   = fetch_pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q[0];
  assign pc_out     = pc_out_q;
  assign q_count    = count_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: expected issue addresses are queued as stimulus is
// applied and compared, in order, against every instruction the controller issues.
module tb_if_fetch_ctrl;

  localparam logic [31:0] JMP_SELF = 32'hA800_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic [2:0]  q_count;
  logic        halted;

  logic [31:0] rom [1024];
  logic [31:0] sb [$];
  int          checks = 0;
  int          errors = 0;

  if_fetch_ctrl #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .inst_valid(inst_valid), .inst(inst), .pc_out(pc_out),
    .q_count(q_count), .halted(halted)
  );

  assign rom_inst = rom[rom_addr[11:2]];

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One reset edge, then release; caller sees the first post-reset cycle.
  task automatic restart(input logic hold);
    rst = 1'b0; br_taken = 1'b0; stall = hold;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0;
    tick(); tick();
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || pc_out !== 32'h0 || q_count !== 3'd0 ||
        rom_addr !== 32'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b inst=%h pc_out=%h cnt=%0d addr=%h halted=%b required 0/0/0/0/0/0",
               inst_valid, inst, pc_out, q_count, rom_addr, halted);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    restart(1'b0);
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL stream_first_cycle: valid=%b required 0", inst_valid);
    end
    for (int k = 0; k < 10; k++) sb.push_back(32'(k * 4));
    tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (inst_valid !== 1'b1) begin
        errors++; $display("FAIL stream_gap: cycle %0d valid=%b required 1", c, inst_valid);
      end else if (!stall && !br_taken) begin
        exp = sb.pop_front();
        if (inst !== rom[exp[11:2]] || pc_out !== exp + 32'd4) begin
          errors++;
          $display("FAIL stream_issue: inst=%h pc_out=%h required inst=%h pc_out=%h",
                   inst, pc_out, rom[exp[11:2]], exp + 32'd4);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL stream_left: %0d pending required 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    restart(1'b1);
    repeat (8) tick();
    checks++;
    if (q_count !== 3'd4 || rom_addr !== 32'h10 || inst_valid !== 1'b1 || inst !== rom[0]) begin
      errors++;
      $display("FAIL stall_full: cnt=%0d addr=%h valid=%b inst=%h required 4/00000010/1/%h",
               q_count, rom_addr, inst_valid, inst, rom[0]);
    end
    stall = 1'b0;
    for (int k = 0; k < 5; k++) sb.push_back(32'(k * 4));
    for (int c = 0; c < 5; c++) begin
      checks++;
      exp = sb.pop_front();
      if (inst_valid !== 1'b1 || inst !== rom[exp[11:2]] || pc_out !== exp + 32'd4) begin
        errors++;
        $display("FAIL stall_release: valid=%b inst=%h pc_out=%h required 1/%h/%h",
                 inst_valid, inst, pc_out, rom[exp[11:2]], exp + 32'd4);
      end
      tick();
    end
  endtask

  task automatic test_branch(input logic with_stall);
    logic [31:0] exp;
    restart(1'b1);
    repeat (3) tick();
    checks++;
    if (q_count !== 3'd3) begin
      errors++; $display("FAIL branch_fill: cnt=%0d required 3", q_count);
    end
    br_taken = 1'b1; br_target = 32'h70; stall = with_stall;
    tick();
    br_taken = 1'b0; stall = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || q_count !== 3'd0 || rom_addr !== 32'h70 || inst !== 32'h0) begin
      errors++;
      $display("FAIL branch_bubble(stall=%b): valid=%b cnt=%0d addr=%h inst=%h required 0/0/00000070/0",
               with_stall, inst_valid, q_count, rom_addr, inst);
    end
    tick();
    sb.push_back(32'h70); sb.push_back(32'h74); sb.push_back(32'h78);
    for (int c = 0; c < 3; c++) begin
      checks++;
      exp = sb.pop_front();
      if (inst_valid !== 1'b1 || inst !== rom[exp[11:2]] || pc_out !== exp + 32'd4) begin
        errors++;
        $display("FAIL branch_target(stall=%b): valid=%b inst=%h pc_out=%h required 1/%h/%h",
                 with_stall, inst_valid, inst, pc_out, rom[exp[11:2]], exp + 32'd4);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    restart(1'b1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; stall = 1'b0;
    checks++;
    if (q_count !== 3'd0 || inst_valid !== 1'b0 || rom_addr !== 32'h0 || inst !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: cnt=%0d valid=%b addr=%h inst=%h required 0/0/0/0",
               q_count, inst_valid, rom_addr, inst);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst !== rom[0] || pc_out !== 32'h4) begin
      errors++;
      $display("FAIL reset_mid_restart: valid=%b inst=%h pc_out=%h required 1/%h/00000004",
               inst_valid, inst, pc_out, rom[0]);
    end
  endtask

  task automatic test_redirect_chain();
    logic [31:0] exp;
    restart(1'b0);
    tick(); tick();
    br_taken = 1'b1; br_target = 32'h70;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 32'h70) begin
      errors++; $display("FAIL redir1: valid=%b addr=%h required 0/00000070", inst_valid, rom_addr);
    end
    br_target = 32'h100;
    tick();
    br_taken = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 32'h100) begin
      errors++; $display("FAIL redir2: valid=%b addr=%h required 0/00000100", inst_valid, rom_addr);
    end
    tick();
    sb.push_back(32'h100); sb.push_back(32'h104);
    for (int c = 0; c < 2; c++) begin
      checks++;
      exp = sb.pop_front();
      if (inst_valid !== 1'b1 || inst !== rom[exp[11:2]] || pc_out !== exp + 32'd4) begin
        errors++;
        $display("FAIL redir_target: valid=%b inst=%h pc_out=%h required 1/%h/%h",
                 inst_valid, inst, pc_out, rom[exp[11:2]], exp + 32'd4);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
    tick();
    br_taken = 1'b0;
    tick();
    sb.push_back(32'hFFFF_FFF8); sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      exp = sb.pop_front();
      if (inst_valid !== 1'b1 || inst !== rom[exp[11:2]] || pc_out !== exp + 32'd4) begin
        errors++;
        $display("FAIL wrap: valid=%b inst=%h pc_out=%h required 1/%h/%h",
                 inst_valid, inst, pc_out, rom[exp[11:2]], exp + 32'd4);
      end
      tick();
    end
  endtask

  task automatic test_halt();
`ifdef HALT_DETECT_EN
    br_taken = 1'b1; br_target = 32'h1C0;
    tick();
    br_taken = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst !== JMP_SELF || pc_out !== 32'h1C4) begin
      errors++;
      $display("FAIL halt_issue: valid=%b inst=%h pc_out=%h required 1/%h/000001c4",
               inst_valid, inst, pc_out, JMP_SELF);
    end
    tick();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (halted !== 1'b1 || inst_valid !== 1'b0) begin
        errors++; $display("FAIL halt_hold: cycle %0d halted=%b valid=%b required 1/0", c, halted, inst_valid);
      end
      tick();
    end
    br_taken = 1'b1; br_target = 32'h0;
    tick();
    br_taken = 1'b0;
    tick();
    checks++;
    if (halted !== 1'b0 || inst_valid !== 1'b1 || inst !== rom[0]) begin
      errors++;
      $display("FAIL halt_exit: halted=%b valid=%b inst=%h required 0/1/%h", halted, inst_valid, inst, rom[0]);
    end
`else
    // Act as the EXE stage: every issued JMP -1 is answered with a redirect to itself.
    for (int k = 0; k < 3; k++) begin
      br_taken = 1'b1; br_target = 32'h1C0;
      tick();
      br_taken = 1'b0;
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst !== JMP_SELF || pc_out !== 32'h1C4 || halted !== 1'b0) begin
        errors++;
        $display("FAIL self_loop: pass %0d valid=%b inst=%h pc_out=%h halted=%b required 1/%h/000001c4/0",
                 k, inst_valid, inst, pc_out, halted, JMP_SELF);
      end
      tick();
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hC0DE_0000 | 32'(i);
    rom[112] = JMP_SELF;
    test_reset();
    test_stream();
    test_stall();
    test_branch(1'b0);
    test_branch(1'b1);
    test_reset_mid();
    test_redirect_chain();
    test_wrap();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
